// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS datapath.
// Shift-add multiply and restoring divide, one bit per cycle, with a pipeline Stall interlock.
module muldiv_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [2:0]  RTYPE_ALUOP = 3'b111
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            ALUOp,
    input  logic [5:0]            ALUFunction,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  busy,
    output logic                  done,
    output logic                  div0,
    output logic                  Stall
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e         r_state, w_state_nxt;
    logic [2*W-1:0] r_prod, w_prod_nxt;
    logic [W-1:0]   r_b, w_b_nxt;
    logic [W-1:0]   r_hi, w_hi_nxt;
    logic [W-1:0]   r_lo, w_lo_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           r_is_div, w_is_div_nxt;
    logic           r_neg_q, w_neg_q_nxt;
    logic           r_neg_r, w_neg_r_nxt;
    logic           r_div0, w_div0_nxt;

    logic w_rtype, w_is_mult, w_is_div, w_signed_op, w_launch, w_busy, w_accept;
    logic w_mfhi, w_mflo, w_mthi, w_mtlo;

    assign w_rtype     = start && (ALUOp == RTYPE_ALUOP);
    assign w_is_mult   = w_rtype && ((ALUFunction == F_MULT) || (ALUFunction == F_MULTU));
    assign w_is_div    = w_rtype && ((ALUFunction == F_DIV) || (ALUFunction == F_DIVU));
    assign w_signed_op = (ALUFunction == F_MULT) || (ALUFunction == F_DIV);
    assign w_launch    = w_is_mult || w_is_div;
    assign w_mfhi      = w_rtype && (ALUFunction == F_MFHI);
    assign w_mflo      = w_rtype && (ALUFunction == F_MFLO);
    assign w_mthi      = w_rtype && (ALUFunction == F_MTHI);
    assign w_mtlo      = w_rtype && (ALUFunction == F_MTLO);
    assign w_busy      = (r_state == StCalc) || (r_state == StFix);
    assign w_accept    = w_launch && !w_busy;

    logic [W-1:0] w_abs_a, w_abs_b;
    assign w_abs_a = (w_signed_op && A[W-1]) ? -A : A;
    assign w_abs_b = (w_signed_op && B[W-1]) ? -B : B;

    // Multiply step: conditionally add multiplicand into the upper half, then shift right.
    logic [W:0]     w_sum;
    logic [2*W-1:0] w_mul_step;
    assign w_sum      = {1'b0, r_prod[2*W-1:W]} + {1'b0, r_b};
    assign w_mul_step = r_prod[0] ? {w_sum, r_prod[W-1:1]} : {1'b0, r_prod[2*W-1:1]};

    // Divide step: r_prod holds {remainder, dividend/quotient}; trial-subtract after a left shift.
    logic [W:0]     w_diff;
    logic [2*W-1:0] w_div_step;
    assign w_diff     = r_prod[2*W-1:W-1] - {1'b0, r_b};
    assign w_div_step = w_diff[W] ? {r_prod[2*W-2:0], 1'b0}
                                  : {w_diff[W-1:0], r_prod[W-2:0], 1'b1};

    logic [2*W-1:0] w_mul_res;
    logic [W-1:0]   w_quo, w_rem;
    assign w_mul_res = r_neg_q ? -r_prod : r_prod;
    assign w_quo     = r_neg_q ? -r_prod[W-1:0] : r_prod[W-1:0];
    assign w_rem     = r_neg_r ? -r_prod[2*W-1:W] : r_prod[2*W-1:W];

    always_comb begin
        w_state_nxt  = r_state;
        w_prod_nxt   = r_prod;
        w_b_nxt      = r_b;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_cnt_nxt    = r_cnt;
        w_is_div_nxt = r_is_div;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_div0_nxt   = 1'b0;
        case (r_state)
            StIdle, StDone: begin
                w_state_nxt = StIdle;
                if (w_accept) begin
                    w_prod_nxt   = {{W{1'b0}}, w_abs_a};
                    w_b_nxt      = w_abs_b;
                    w_cnt_nxt    = '0;
                    w_is_div_nxt = w_is_div;
                    w_neg_q_nxt  = w_signed_op && (A[W-1] ^ B[W-1]);
                    w_neg_r_nxt  = w_signed_op && A[W-1];
                    if (w_is_div && (B == '0)) begin
                        w_state_nxt = StDone;
                        w_div0_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = StCalc;
                    end
                end else if (w_mthi) begin
                    w_hi_nxt = A;
                end else if (w_mtlo) begin
                    w_lo_nxt = A;
                end
            end
            StCalc: begin
                w_prod_nxt = r_is_div ? w_div_step : w_mul_step;
                w_cnt_nxt  = r_cnt + CW'(1);
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = StFix;
                end
            end
            StFix: begin
                w_state_nxt = StDone;
                if (r_is_div) begin
                    w_hi_nxt = w_rem;
                    w_lo_nxt = w_quo;
                end else begin
                    {w_hi_nxt, w_lo_nxt} = w_mul_res;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= StIdle;
            r_prod   <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_prod   <= w_prod_nxt;
            r_b      <= w_b_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_div <= w_is_div_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_div0   <= w_div0_nxt;
        end
    end

    assign HI       = r_hi;
    assign LO       = r_lo;
    assign busy     = w_busy;
    assign done     = (r_state == StDone);
    assign div0     = r_div0;
    assign Stall    = w_busy && (w_launch || w_mfhi || w_mflo || w_mthi || w_mtlo);
    assign ReadData = w_mfhi ? r_hi : (w_mflo ? r_lo : '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of multiply/divide ops plus
// hand sequences for stall, MTHI/MFHI, decode filtering, back-to-back and mid-op reset.
module tb_muldiv_unit;

    localparam logic [2:0] RT      = 3'b111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  ALUOp;
    logic [5:0]  ALUFunction;
    logic [31:0] A, B, HI, LO, ReadData;
    logic        busy, done, div0, Stall;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit #(.DATA_WIDTH(32), .RTYPE_ALUOP(3'b111)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .ALUFunction(ALUFunction),
        .A(A), .B(B), .HI(HI), .LO(LO), .ReadData(ReadData),
        .busy(busy), .done(done), .div0(div0), .Stall(Stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        d0;
        int          lat;
        int          bsy;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Launch one op, wait (bounded) for done, check latency, busy length and results.
    task automatic run_vec(input int idx, input vec_t v);
        int n = 0;
        int bc = 0;
        start = 1'b1; ALUOp = v.op; ALUFunction = v.fn; A = v.a; B = v.b;
        tick();
        n = 1;
        start = 1'b0; A = '0; B = '0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) bc++;
            tick();
            n++;
        end
        chk($sformatf("v%0d latency", idx), n, v.lat);
        chk($sformatf("v%0d busy cycles", idx), bc, v.bsy);
        chk($sformatf("v%0d HI", idx), HI, v.hi);
        chk($sformatf("v%0d LO", idx), LO, v.lo);
        chk($sformatf("v%0d div0", idx), {31'b0, div0}, {31'b0, v.d0});
        chk($sformatf("v%0d busy at done", idx), {31'b0, busy}, 32'd0);
        tick();
        chk($sformatf("v%0d done pulse", idx), {31'b0, done}, 32'd0);
        chk($sformatf("v%0d div0 clear", idx), {31'b0, div0}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, hl_bad;

        vecs[0]  = '{RT, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 34, 33};
        vecs[1]  = '{RT, F_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0, 34, 33};
        vecs[2]  = '{RT, F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34, 33};
        vecs[3]  = '{RT, F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 34, 33};
        vecs[4]  = '{RT, F_DIVU,  32'd100,      32'd0,        32'h00000000, 32'h80000000, 1, 1, 0};
        vecs[5]  = '{RT, F_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 0, 34, 33};
        vecs[6]  = '{RT, F_MULT,  32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 0, 34, 33};
        vecs[7]  = '{RT, F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 34, 33};
        vecs[8]  = '{RT, F_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 0, 34, 33};
        vecs[9]  = '{RT, F_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 0, 34, 33};
        vecs[10] = '{RT, F_DIV,   32'd5,        32'd0,        32'h00000001, 32'h23456780, 1, 1, 0};
        vecs[11] = '{RT, F_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 0, 34, 33};

        reset = 1'b0; start = 1'b0; ALUOp = '0; ALUFunction = '0; A = '0; B = '0;
        repeat (3) tick();
        start = 1'b1; ALUOp = RT; ALUFunction = F_MFHI;
        #1;
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        chk("reset busy/done/div0/Stall", {28'b0, busy, done, div0, Stall}, 32'd0);
        chk("reset ReadData", ReadData, 32'd0);
        start = 1'b0;
        reset = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // DIVU 1000/3 with MFLO held and a MULT injected mid-operation.
        start = 1'b1; ALUOp = RT; ALUFunction = F_DIVU; A = 32'd1000; B = 32'd3;
        tick();
        n = 1; bad = 0; hl_bad = 0;
        while (done !== 1'b1 && n < 100) begin
            if (n == 10) begin
                ALUFunction = F_MULT; A = 32'd3; B = 32'd3;
            end else begin
                ALUFunction = F_MFLO; A = '0; B = '0;
            end
            #1;
            if (Stall !== 1'b1) bad++;
            if (HI !== 32'hFFFFFFFF || LO !== 32'h00000003) hl_bad++;
            tick();
            n++;
        end
        ALUFunction = F_MFLO;
        #1;
        chk("stall latency", n, 34);
        chk("stall cycles without Stall", bad, 0);
        chk("HI/LO changed while busy", hl_bad, 0);
        chk("Stall in DONE", {31'b0, Stall}, 32'd0);
        chk("ReadData new LO", ReadData, 32'd333);
        chk("divu HI", HI, 32'd1);
        start = 1'b0;
        bad = 0;
        repeat (5) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("ignored MULT activity", bad, 0);
        chk("LO after ignored MULT", LO, 32'd333);

        // MTHI / MFHI / MTLO.
        start = 1'b1; ALUOp = RT; ALUFunction = F_MTHI; A = 32'h12345678;
        tick();
        chk("MTHI busy", {31'b0, busy}, 32'd0);
        chk("MTHI HI", HI, 32'h12345678);
        ALUFunction = F_MFHI; A = '0;
        #1;
        chk("MFHI ReadData", ReadData, 32'h12345678);
        chk("MFHI Stall", {31'b0, Stall}, 32'd0);
        ALUFunction = F_MTLO; A = 32'hCAFEF00D;
        tick();
        chk("MTLO LO", LO, 32'hCAFEF00D);
        chk("MTLO keeps HI", HI, 32'h12345678);

        // Non-R-type ALUOp carrying a MULT funct must do nothing.
        ALUOp = 3'b100; ALUFunction = F_MULT; A = 32'd9; B = 32'd9;
        bad = 0;
        repeat (5) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("non-rtype activity", bad, 0);
        chk("non-rtype LO", LO, 32'hCAFEF00D);
        start = 1'b0;
        tick();

        // Back-to-back: second launch sampled in the DONE cycle of the first.
        start = 1'b1; ALUOp = RT; ALUFunction = F_MULTU; A = 32'd3; B = 32'd4;
        tick();
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("b2b first LO", LO, 32'd12);
        start = 1'b1; A = 32'd5; B = 32'd5;
        tick();
        start = 1'b0;
        chk("b2b relaunch busy/done", {30'b0, busy, done}, 32'd2);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("b2b second latency", n, 34);
        chk("b2b second LO", LO, 32'd25);
        tick();

        // Reset 10 cycles into a MULT.
        start = 1'b1; ALUOp = RT; ALUFunction = F_MULT; A = 32'd5; B = 32'd9;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        chk("mid-op reset HI/LO", HI | LO, 32'd0);
        chk("mid-op reset flags", {28'b0, busy, done, div0, Stall}, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        begin
            vec_t v;
            v = '{RT, F_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 0, 34, 33};
            run_vec(12, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
